// File: rtl/wrr_arb_pkg.sv
// Shared helpers for the weighted round-robin arbiter: effective weight and
// circular first-one search from a priority pointer.
package wrr_arb_pkg;

   // Upper bound on NumIn supported by the circular search helper.
   localparam int unsigned MaxNumIn = 256;

   function automatic int unsigned weff(input int unsigned w);
      return (w == 32'd0) ? 32'd1 : w;
   endfunction

   // First set bit of req at or after ptr, wrapping modulo n; 0 when none set.
   function automatic int unsigned first_one_from(input logic [MaxNumIn-1:0] req,
                                                  input int unsigned ptr,
                                                  input int unsigned n);
      int unsigned idx;
      logic        found;
      first_one_from = 32'd0;
      found          = 1'b0;
      for (int unsigned i = 0; i < MaxNumIn; i++) begin
         idx = ptr + i;
         if (idx >= n) begin
            idx = idx - n;
         end else begin
            idx = idx;
         end
         if (i < n && !found && req[idx[7:0]]) begin
            found          = 1'b1;
            first_one_from = idx;
         end else begin
            found = found;
         end
      end
   endfunction

endpackage

// File: rtl/wrr_arb_chk.sv
// Protocol properties of the arbiter output and the stalled-request assumption.
module wrr_arb_chk #(
   parameter int   NumIn    = 8,
   parameter int   IdxWidth = 3,
   parameter logic LockIn   = 1'b1
) (
   input logic                clk_i,
   input logic                rst_ni,
   input logic                flush_i,
   input logic [NumIn-1:0]    req_i,
   input logic                gnt_i,
   input logic                req_o,
   input logic [NumIn-1:0]    gnt_o,
   input logic [IdxWidth-1:0] idx_o
);

   logic [NumIn-1:0] w_idx_mask;
   logic             w_stall;

   // Decode the reported winner and detect a lock-worthy stall.
   always_comb begin
      w_idx_mask = NumIn'(1) << idx_o;
      w_stall    = LockIn & req_o & ~gnt_i & ~flush_i;
   end

   a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(gnt_o)) else $error("gnt_o not one-hot0");

   a_gnt_needs_gnt_i: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (|gnt_o) |-> gnt_i) else $error("gnt_o without gnt_i");

   a_gnt_at_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (gnt_i && req_o) |-> |(gnt_o & w_idx_mask)) else $error("grant not at idx_o");

   a_stall_idx_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_stall |=> $stable(idx_o)) else $error("idx_o moved during stall");

   a_stall_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_stall |=> |(req_i & $past(w_idx_mask))) else $error("stalled request dropped");

endmodule

// File: rtl/wrr_prio_sel.sv
// Combinational circular priority select: first requester at or after the
// pointer, returned as valid flag, binary index and one-hot vector.
module wrr_prio_sel
   import wrr_arb_pkg::*;
#(
   parameter int NumIn    = 8,
   parameter int IdxWidth = 3
) (
   input  logic [NumIn-1:0]    req_i,
   input  logic [IdxWidth-1:0] ptr_i,
   output logic                valid_o,
   output logic [IdxWidth-1:0] idx_o,
   output logic [NumIn-1:0]    onehot_o
);

   logic [MaxNumIn-1:0] w_req_ext;
   int unsigned         w_idx;

   // Zero-extend the request vector and run the circular search.
   always_comb begin
      w_req_ext            = '0;
      w_req_ext[NumIn-1:0] = req_i;
      w_idx                = first_one_from(w_req_ext, 32'(ptr_i), NumIn);
      valid_o              = |req_i;
      idx_o                = IdxWidth'(w_idx);
      if (valid_o) begin
         onehot_o = NumIn'(1) << w_idx;
      end else begin
         onehot_o = '0;
      end
   end

endmodule

// File: rtl/wrr_arb_tree.sv
// Weighted round-robin arbiter: each input may take up to its weight in
// consecutive grants before priority moves on; decision locked while stalled.
module wrr_arb_tree
   import wrr_arb_pkg::*;
#(
   parameter int   NumIn       = 8,
   parameter int   DataWidth   = 32,
   parameter int   WeightWidth = 4,
   parameter logic LockIn      = 1'b1,
   parameter int   IdxWidth    = (NumIn > 1) ? $clog2(NumIn) : 1
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                flush_i,
   input  logic [NumIn-1:0][WeightWidth-1:0]   weight_i,
   input  logic [NumIn-1:0]                    req_i,
   output logic [NumIn-1:0]                    gnt_o,
   input  logic [NumIn-1:0][DataWidth-1:0]     data_i,
   output logic                                req_o,
   input  logic                                gnt_i,
   output logic [DataWidth-1:0]                data_o,
   output logic [IdxWidth-1:0]                 idx_o
);

   assign req_o = |req_i;

   if (NumIn == 1) begin : g_pass
      logic w_unused;
      assign w_unused = ^{weight_i, flush_i};

      // Single requester: straight passthrough.
      always_comb begin
         idx_o = '0;
         gnt_o = req_i & {NumIn{gnt_i}};
         if (req_o) begin
            data_o = data_i[0];
         end else begin
            data_o = '0;
         end
      end
   end else begin : g_arb
      logic [IdxWidth-1:0]    r_rr;
      logic [WeightWidth-1:0] r_cnt;
      logic                   r_lock;
      logic [IdxWidth-1:0]    r_lock_idx;
      logic                   w_sel_valid;
      logic [IdxWidth-1:0]    w_sel_idx;
      logic [NumIn-1:0]       w_sel_onehot;
      logic [IdxWidth-1:0]    w_win;
      logic                   w_hs;
      int unsigned            w_used;
      int unsigned            w_weff;
      logic                   w_unused;

      assign w_unused = ^{w_sel_valid, w_sel_onehot};

      wrr_prio_sel #(
         .NumIn    (NumIn),
         .IdxWidth (IdxWidth)
      ) u_prio_sel (
         .req_i    (req_i),
         .ptr_i    (r_rr),
         .valid_o  (w_sel_valid),
         .idx_o    (w_sel_idx),
         .onehot_o (w_sel_onehot)
      );

      // Winner selection, outputs and credit accounting for this cycle.
      always_comb begin
         if (r_lock) begin
            w_win = r_lock_idx;
         end else begin
            w_win = w_sel_idx;
         end
         w_hs   = req_o & gnt_i;
         w_weff = weff(32'(weight_i[w_win]));
         if (w_win == r_rr) begin
            w_used = 32'(r_cnt) + 32'd1;
         end else begin
            w_used = 32'd1;
         end
         gnt_o = '0;
         if (req_o) begin
            idx_o  = w_win;
            data_o = data_i[w_win];
            gnt_o[w_win] = gnt_i;
         end else begin
            idx_o  = '0;
            data_o = '0;
         end
      end

      // Pointer/credit/lock state; flush wins over a same-cycle handshake.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_rr       <= '0;
            r_cnt      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
         end else if (flush_i) begin
            r_rr       <= '0;
            r_cnt      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
         end else begin
            if (w_hs) begin
               if (w_used < w_weff) begin
                  r_rr  <= w_win;
                  r_cnt <= WeightWidth'(w_used);
               end else begin
                  r_rr  <= (w_win == IdxWidth'(NumIn - 1)) ? '0 : w_win + IdxWidth'(1);
                  r_cnt <= '0;
               end
            end else begin
               r_rr  <= r_rr;
               r_cnt <= r_cnt;
            end
            r_lock     <= LockIn & req_o & ~gnt_i;
            r_lock_idx <= w_win;
         end
      end
   end

   wrr_arb_chk #(
      .NumIn    (NumIn),
      .IdxWidth (IdxWidth),
      .LockIn   (LockIn)
   ) u_chk (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .req_i   (req_i),
      .gnt_i   (gnt_i),
      .req_o   (req_o),
      .gnt_o   (gnt_o),
      .idx_o   (idx_o)
   );

endmodule

// File: tb/tb_wrr_arb_tree.sv
// Self-checking bench: spec-derived vector table, hand sequences for lock,
// reset and wrap corners, and random traffic against a reference model.
module tb_wrr_arb_tree;

   logic clk_i = 1'b0;
   logic rst_ni;
   always #5 clk_i = ~clk_i;

   // Main instance: 4 inputs, lock enabled
   logic                  f4;
   logic [3:0][3:0]       wt4;
   logic [3:0]            req4, gnt4_o;
   logic [3:0][31:0]      dat4;
   logic                  req4_o, gnt4_i;
   logic [31:0]           dat4_o;
   logic [1:0]            idx4_o;

   // 5 inputs, lock disabled, 8-bit payload
   logic                  f5;
   logic [4:0][3:0]       wt5;
   logic [4:0]            req5, gnt5_o;
   logic [4:0][7:0]       dat5;
   logic                  req5_o, gnt5_i;
   logic [7:0]            dat5_o;
   logic [2:0]            idx5_o;

   // Single-input passthrough
   logic                  f1;
   logic [0:0][3:0]       wt1;
   logic [0:0]            req1, gnt1_o;
   logic [0:0][15:0]      dat1;
   logic                  req1_o, gnt1_i;
   logic [15:0]           dat1_o;
   logic [0:0]            idx1_o;

   wrr_arb_tree #(.NumIn(4), .DataWidth(32), .WeightWidth(4), .LockIn(1'b1)) u_dut4 (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(f4), .weight_i(wt4), .req_i(req4),
      .gnt_o(gnt4_o), .data_i(dat4), .req_o(req4_o), .gnt_i(gnt4_i), .data_o(dat4_o),
      .idx_o(idx4_o));

   wrr_arb_tree #(.NumIn(5), .DataWidth(8), .WeightWidth(4), .LockIn(1'b0)) u_dut5 (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(f5), .weight_i(wt5), .req_i(req5),
      .gnt_o(gnt5_o), .data_i(dat5), .req_o(req5_o), .gnt_i(gnt5_i), .data_o(dat5_o),
      .idx_o(idx5_o));

   wrr_arb_tree #(.NumIn(1), .DataWidth(16), .WeightWidth(4), .LockIn(1'b0)) u_dut1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(f1), .weight_i(wt1), .req_i(req1),
      .gnt_o(gnt1_o), .data_i(dat1), .req_o(req1_o), .gnt_i(gnt1_i), .data_o(dat1_o),
      .idx_o(idx1_o));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] wt;
      logic [3:0]  req;
      logic        gnt;
      logic        flush;
      logic [1:0]  idx;
      logic [3:0]  gexp;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [15:0] wt, input logic [3:0] req, input logic gnt,
                               input logic flush, input logic [1:0] idx, input logic [3:0] gexp);
      vec_t v;
      v.wt = wt; v.req = req; v.gnt = gnt; v.flush = flush; v.idx = idx; v.gexp = gexp;
      tbl.push_back(v);
   endfunction

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk4(input string name, input logic [1:0] idx, input logic [3:0] gexp);
      @(negedge clk_i);
      chk({name, " idx"}, 64'(idx4_o), 64'(idx));
      chk({name, " gnt"}, 64'(gnt4_o), 64'(gexp));
   endtask

   // Reference model for the 4-input instance
   int m_ptr, m_used, m_lock_idx;
   bit m_lock;

   function automatic int m_pick(input logic [3:0] r);
      if (m_lock) return m_lock_idx;
      for (int k = 0; k < 4; k++) begin
         if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      end
      return 0;
   endfunction

   function automatic void m_update(input logic [3:0] r, input logic g, input logic fl,
                                    input logic [3:0][3:0] w);
      int win, eff, u;
      win = m_pick(r);
      if (fl) begin
         m_ptr = 0; m_used = 0; m_lock = 1'b0; m_lock_idx = 0;
      end else begin
         if (|r && g) begin
            eff = (w[win] == 4'd0) ? 1 : int'(w[win]);
            u   = (win == m_ptr) ? m_used + 1 : 1;
            if (u < eff) begin
               m_ptr = win; m_used = u;
            end else begin
               m_ptr = (win + 1) % 4; m_used = 0;
            end
         end
         m_lock     = (|r) && !g;
         m_lock_idx = win;
      end
   endfunction

   initial begin
      int w;
      rst_ni = 1'b0;
      f4 = 1'b0; wt4 = '0; req4 = '0; gnt4_i = 1'b0;
      f5 = 1'b0; wt5 = '0; req5 = '0; gnt5_i = 1'b0;
      f1 = 1'b0; wt1 = '0; req1 = '0; gnt1_i = 1'b0;
      for (int k = 0; k < 4; k++) dat4[k] = 32'hDA7A_0000 + 32'(k);
      for (int k = 0; k < 5; k++) dat5[k] = 8'h50 + 8'(k);
      dat1[0] = 16'hBEEF;

      // Reset state
      @(negedge clk_i);
      chk("rst req_o", 64'(req4_o), 64'd0);
      chk("rst idx", 64'(idx4_o), 64'd0);
      chk("rst data", 64'(dat4_o), 64'd0);
      req4 = 4'b0110;
      @(negedge clk_i);
      chk("rst lowest idx", 64'(idx4_o), 64'd1);
      chk("rst gnt", 64'(gnt4_o), 64'd0);
      req4 = 4'b0000;
      @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // Weighted sequence, holder dropout, flush vs handshake
      add(16'h1321, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000);
      w = 0;
      foreach (tbl[i]) w = w;
      begin
         int seq[10] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
         for (int k = 0; k < 10; k++)
            add(16'h1321, 4'b1111, 1'b1, 1'b0, 2'(seq[k]), 4'(4'b0001 << seq[k]));
      end
      add(16'h3333, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000);
      add(16'h3333, 4'b0011, 1'b1, 1'b0, 2'd0, 4'b0001);
      for (int k = 0; k < 4; k++) add(16'h3333, 4'b0010, 1'b1, 1'b0, 2'd1, 4'b0010);
      add(16'h3333, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000);
      add(16'h3333, 4'b0011, 1'b1, 1'b0, 2'd0, 4'b0001);
      add(16'h3333, 4'b0011, 1'b1, 1'b1, 2'd0, 4'b0001);
      for (int k = 0; k < 3; k++) add(16'h3333, 4'b0011, 1'b1, 1'b0, 2'd0, 4'b0001);
      add(16'h3333, 4'b0011, 1'b1, 1'b0, 2'd1, 4'b0010);

      foreach (tbl[i]) begin
         wt4 = tbl[i].wt; req4 = tbl[i].req; gnt4_i = tbl[i].gnt; f4 = tbl[i].flush;
         @(negedge clk_i);
         chk($sformatf("tbl%0d idx", i), 64'(idx4_o), 64'(tbl[i].idx));
         chk($sformatf("tbl%0d gnt", i), 64'(gnt4_o), 64'(tbl[i].gexp));
         chk($sformatf("tbl%0d req_o", i), 64'(req4_o), 64'(|tbl[i].req));
         chk($sformatf("tbl%0d data", i), 64'(dat4_o),
             (|tbl[i].req) ? 64'(dat4[tbl[i].idx]) : 64'd0);
         next_cycle();
      end
      f4 = 1'b0;

      // Lock holds index 1 through a stall even when input 0 appears
      f4 = 1'b1; req4 = '0; gnt4_i = 1'b0;
      next_cycle();
      f4 = 1'b0; req4 = 4'b0110;
      chk4("lock c1", 2'd1, 4'b0000);
      next_cycle();
      req4 = 4'b0111;
      chk4("lock c2", 2'd1, 4'b0000);
      next_cycle();
      chk4("lock c3", 2'd1, 4'b0000);
      next_cycle();
      gnt4_i = 1'b1;
      chk4("lock release", 2'd1, 4'b0010);
      next_cycle();

      // Reset while locked on input 3
      req4 = 4'b1000; gnt4_i = 1'b0;
      chk4("prelock", 2'd3, 4'b0000);
      next_cycle();
      rst_ni = 1'b0;
      chk4("in reset", 2'd3, 4'b0000);
      next_cycle();
      rst_ni = 1'b1; gnt4_i = 1'b1;
      chk4("post reset", 2'd3, 4'b1000);
      next_cycle();

      // Weight-0 and wrap on 5 inputs, then no lock with LockIn=0
      req4 = '0; gnt4_i = 1'b0;
      req5 = 5'b10001; gnt5_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         chk($sformatf("n5 alt%0d idx", k), 64'(idx5_o), (k % 2 == 0) ? 64'd0 : 64'd4);
         chk($sformatf("n5 alt%0d data", k), 64'(dat5_o), (k % 2 == 0) ? 64'h50 : 64'h54);
         next_cycle();
      end
      req5 = 5'b00010; gnt5_i = 1'b0;
      @(negedge clk_i);
      chk("n5 stall idx", 64'(idx5_o), 64'd1);
      next_cycle();
      req5 = 5'b00011;
      @(negedge clk_i);
      chk("n5 nolock idx", 64'(idx5_o), 64'd0);
      next_cycle();
      req5 = '0;

      // Single-input passthrough
      req1 = 1'b1; gnt1_i = 1'b1; wt1 = '1;
      @(negedge clk_i);
      chk("n1 gnt", 64'(gnt1_o), 64'd1);
      chk("n1 data", 64'(dat1_o), 64'hBEEF);
      chk("n1 idx", 64'(idx1_o), 64'd0);
      next_cycle();
      req1 = 1'b0;
      @(negedge clk_i);
      chk("n1 idle", 64'({req1_o, gnt1_o, dat1_o}), 64'd0);
      next_cycle();
      gnt1_i = 1'b0;

      // Random traffic against the reference model
      f4 = 1'b1; req4 = '0; gnt4_i = 1'b0;
      next_cycle();
      m_ptr = 0; m_used = 0; m_lock = 1'b0; m_lock_idx = 0;
      f4 = 1'b0; wt4 = 16'h2413;
      for (int c = 0; c < 400; c++) begin
         req4 = 4'($urandom_range(0, 15));
         if (m_lock) req4[m_lock_idx] = 1'b1;
         gnt4_i = ($urandom_range(0, 9) < 6);
         f4 = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 19) == 0) wt4 = 16'($urandom);
         for (int k = 0; k < 4; k++) dat4[k] = $urandom;
         w = m_pick(req4);
         @(negedge clk_i);
         chk($sformatf("rnd%0d idx", c), 64'(idx4_o), (|req4) ? 64'(w) : 64'd0);
         chk($sformatf("rnd%0d gnt", c), 64'(gnt4_o),
             (|req4 && gnt4_i) ? 64'(4'b0001 << w) : 64'd0);
         chk($sformatf("rnd%0d data", c), 64'(dat4_o), (|req4) ? 64'(dat4[w]) : 64'd0);
         @(posedge clk_i);
         m_update(req4, gnt4_i, f4, wt4);
         #1;
      end
      req4 = '0; gnt4_i = 1'b0; f4 = 1'b0;
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wrr_arb_tree.md
WRR_ARB_TREE -- requirements
Module: wrr_arb_tree

Interface
REQ-001 SHALL have parameter NumIn, default 8: number of requesters, at least 1, power of two not required.
REQ-002 SHALL have parameter DataWidth, default 32: payload width.
REQ-003 SHALL have parameter WeightWidth, default 4: width of per-input weight.
REQ-004 SHALL have parameter LockIn, default 1'b1: holds the decision while the output is stalled.
REQ-005 SHALL derive IdxWidth = max(1, clog2(NumIn)).
REQ-006 SHALL have one clock; reset is asynchronous and active-low. Ports: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-007 flush_i  in  1  synchronous clear of arbiter state.
REQ-008 weight_i  in  NumIn x WeightWidth  grants per turn per input (quasi-static); value 0 treated as 1.
REQ-009 req_i  in  NumIn  input requests.
REQ-010 gnt_o  out  NumIn  input grants, one-hot or zero.
REQ-011 data_i  in  NumIn x DataWidth  input payloads.
REQ-012 req_o  out  1  arbitrated request.
REQ-013 gnt_i  in  1  downstream grant.
REQ-014 data_o  out  DataWidth  payload of the winner.
REQ-015 idx_o  out  IdxWidth  index of the winner.

Function
REQ-016 State: rr_q (IdxWidth, priority pointer), cnt_q (WeightWidth, grants already used by holder rr_q), lock_q (1), lock_idx_q (IdxWidth).
REQ-017 req_o SHALL equal OR of req_i, combinationally, zero latency.
REQ-018 Unlocked winner w SHALL be the first requesting index at or after rr_q, searching circularly modulo NumIn.
REQ-019 Locked (lock_q=1) winner SHALL be lock_idx_q.
REQ-020 idx_o = w and data_o = data_i[w] when req_o=1; both SHALL be 0 when req_o=0.
REQ-021 gnt_o[w] = gnt_i & req_o; all other gnt_o bits SHALL be 0.
REQ-022 Handshake (req_o & gnt_i): used = (w==rr_q) ? cnt_q+1 : 1.
REQ-023 On handshake, if used < weff[w]: rr_q<=w, cnt_q<=used.
REQ-024 On handshake, if used >= weff[w]: rr_q<=(w+1) mod NumIn with wrap from NumIn-1 to 0, cnt_q<=0.
REQ-025 Without a handshake, rr_q and cnt_q SHALL hold.
REQ-026 If the holder drops its request, the next winner SHALL be found by REQ-018; its credit restarts per REQ-022.
REQ-027 LockIn=1: lock_d = req_o & ~gnt_i and lock_idx_q <= w each cycle. Requesters SHALL keep a stalled request asserted; this is a checked assumption.
REQ-028 LockIn=0: lock_q SHALL stay 0.
REQ-029 Flush SHALL take priority over any simultaneous handshake: rr_q, cnt_q, lock_q, lock_idx_q <= 0.
REQ-030 A weight change SHALL take effect at the next handshake compare. If cnt_q >= the new weff, the next handshake SHALL advance the pointer.
REQ-031 NumIn=1: pure passthrough, no state, weights ignored, idx_o=0.

Reset
REQ-032 Asynchronous reset SHALL set rr_q=0, cnt_q=0, lock_q=0, lock_idx_q=0. Outputs are combinational from these, so gnt_o=0 while gnt_i=0 and idx_o=0 while req_i=0.
REQ-033 Reset mid-burst SHALL discard the remaining credit and lock; the first post-reset winner SHALL be the lowest requesting index.

Structure
REQ-034 Package wrr_arb_pkg SHALL hold the effective-weight function (0 maps to 1) and the circular first-one-from-pointer function.
REQ-035 Sub-module wrr_prio_sel SHALL implement the combinational circular priority select: req, pointer -> valid, index, one-hot.
REQ-036 Concurrent assertions: gnt_o one-hot0; |gnt_o implies gnt_i; gnt_i & req_o implies gnt_o[idx_o]; LockIn stall implies idx_o stable next cycle.

Verification
REQ-037 NumIn=4, weights {1,2,3,1}, req_i=4'b1111, gnt_i=1 -> idx_o sequence 0,1,1,2,2,2,3,0,1,1.
REQ-038 NumIn=4, weights all 3, req_i=4'b0011; req_i[0] drops after 1 grant -> idx_o 0, then 1,1,1, then 1 again with fresh credit after the wrap.
REQ-039 LockIn=1, req_i=4'b0110, gnt_i=0 for 3 cycles, req_i[0] rises in cycle 2 -> idx_o=1 in every stall cycle, then gnt_o=4'b0010 when gnt_i=1.
REQ-040 NumIn=5, weights all 0, req_i=5'b10001, gnt_i=1 -> idx_o alternates 0,4,0,4, checking wrap and the weight-0 rule.
REQ-041 Weights {3,..}, flush_i pulsed after 1 grant to input 0 while req_i=4'b0011 -> cnt_q=0 and rr_q=0; input 0 receives 3 more grants before input 1.
REQ-042 Assert rst_ni low mid-lock with req_i=4'b1000 -> gnt_o=0 during reset; after release idx_o=3 and the first grant goes to input 3.
